// File: rtl/mdu_controller.sv
// ---------------------------------------------------------------------------
// mdu_controller
//
// Multi-cycle sequencer for the RV32M multiply/divide instructions. It sits
// beside the single-cycle ALU in the execute stage. It accepts one operation
// from IDLE, runs exactly XLEN iterations and then sign-corrects and publishes
// the result. Latency is XLEN+1 edges from acceptance to the done pulse, and
// it is the same for every operation.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous, active-high; aborts any operation in progress
//   start      operation request, sampled only while idle
//   func3      RV32M op (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1_value  operand A / dividend
//   rs2_value  operand B / divisor
//   busy       high while an accepted operation is in flight
//   done       one-cycle pulse when result becomes valid
//   result     last completed result, held until overwritten
// ---------------------------------------------------------------------------
module mdu_controller #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] rs2_value,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    localparam logic [5:0]      LAST_ITER = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONE       = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};

    // Architectural state
    state_t            state_q, state_d;
    logic [5:0]        counter_q, counter_d;
    logic [2:0]        op_q, op_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic [XLEN-1:0]   rs1_raw_q, rs1_raw_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d;
    logic [XLEN-1:0]   mag_b_q, mag_b_d;
    // hi/lo form the shared working register: the product for multiply,
    // and the remainder plus the shifting dividend/quotient for divide.
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Input decode used only at acceptance
    logic            in_signed_a;
    logic            in_signed_b;
    logic            in_neg_a;
    logic            in_neg_b;
    logic [XLEN-1:0] in_mag_a;
    logic [XLEN-1:0] in_mag_b;

    // Per-iteration datapath
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_next;
    logic [XLEN-1:0] mul_lo_next;
    logic [XLEN:0]   div_shifted;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [XLEN-1:0] div_hi_next;
    logic [XLEN-1:0] div_lo_next;

    // Sign correction / final result
    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] product_fixed;
    logic [XLEN-1:0]   quotient_fixed;
    logic [XLEN-1:0]   remainder_fixed;
    logic              div_by_zero;
    logic              signed_overflow;
    logic [XLEN-1:0]   final_value;

    // Only the signed operands are converted to magnitudes; MUL keeps both
    // operands unsigned because its low word does not depend on sign.
    always_comb begin
        in_signed_a = (func3 == F_MULH) || (func3 == F_MULHSU) ||
                      (func3 == F_DIV)  || (func3 == F_REM);
        in_signed_b = (func3 == F_MULH) || (func3 == F_DIV) || (func3 == F_REM);
        in_neg_a    = in_signed_a && rs1_value[XLEN-1];
        in_neg_b    = in_signed_b && rs2_value[XLEN-1];
        in_mag_a    = in_neg_a ? (~rs1_value + ONE) : rs1_value;
        in_mag_b    = in_neg_b ? (~rs2_value + ONE) : rs2_value;
    end

    // One shift-add multiply step (right-shifting product, multiplier in lo)
    // and one restoring divide step (left-shifting dividend out of lo,
    // quotient bits shifted into lo). Both are evaluated every cycle; the
    // latched op selects which one updates the working register.
    always_comb begin
        mul_sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mag_a_q : {XLEN{1'b0}})};
        mul_hi_next = mul_sum[XLEN:1];
        mul_lo_next = {mul_sum[0], lo_q[XLEN-1:1]};

        div_shifted = {hi_q, lo_q[XLEN-1]};
        div_diff    = div_shifted - {1'b0, mag_b_q};
        div_ge      = (div_shifted >= {1'b0, mag_b_q});
        div_hi_next = div_ge ? div_diff[XLEN-1:0] : div_shifted[XLEN-1:0];
        div_lo_next = {lo_q[XLEN-2:0], div_ge};
    end

    // Sign correction and the divide special cases. The divide-by-zero and
    // overflow overrides are explicit so the architected values never depend
    // on what the iterative datapath happens to leave behind.
    always_comb begin
        product         = {hi_q, lo_q};
        product_fixed   = (neg_a_q ^ neg_b_q) ? (~product + 1'b1) : product;
        quotient_fixed  = (neg_a_q ^ neg_b_q) ? (~lo_q + ONE) : lo_q;
        remainder_fixed = neg_a_q ? (~hi_q + ONE) : hi_q;
        div_by_zero     = (mag_b_q == {XLEN{1'b0}});
        signed_overflow = neg_a_q && (mag_a_q == MIN_NEG) &&
                          neg_b_q && (mag_b_q == ONE);
        final_value     = '0;

        case (op_q)
            F_MUL:    final_value = product_fixed[XLEN-1:0];
            F_MULH,
            F_MULHSU,
            F_MULHU:  final_value = product_fixed[2*XLEN-1:XLEN];
            F_DIV: begin
                if (div_by_zero)          final_value = ALL_ONES;
                else if (signed_overflow) final_value = MIN_NEG;
                else                      final_value = quotient_fixed;
            end
            F_DIVU:   final_value = div_by_zero ? ALL_ONES : lo_q;
            F_REM: begin
                if (div_by_zero)          final_value = rs1_raw_q;
                else if (signed_overflow) final_value = '0;
                else                      final_value = remainder_fixed;
            end
            F_REMU:   final_value = div_by_zero ? rs1_raw_q : hi_q;
            default:  final_value = '0;
        endcase
    end

    // Next-state and datapath control. The counter reaching XLEN-1 in CALC
    // means the XLEN-th iteration is being performed on this edge.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        op_d      = op_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        rs1_raw_d = rs1_raw_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        result_d  = result_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = func3;
                    neg_a_d   = in_neg_a;
                    neg_b_d   = in_neg_b;
                    rs1_raw_d = rs1_value;
                    mag_a_d   = in_mag_a;
                    mag_b_d   = in_mag_b;
                    counter_d = '0;
                    hi_d      = '0;
                    lo_d      = func3[2] ? in_mag_a : in_mag_b;
                    state_d   = CALC;
                end
            end
            CALC: begin
                counter_d = counter_q + 6'd1;
                if (op_q[2]) begin
                    hi_d = div_hi_next;
                    lo_d = div_lo_next;
                end else begin
                    hi_d = mul_hi_next;
                    lo_d = mul_lo_next;
                end
                if (counter_q == LAST_ITER) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                result_d = final_value;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset drops any operation in
    // flight without producing a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            op_q      <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            rs1_raw_q <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            op_q      <= op_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            rs1_raw_q <= rs1_raw_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    // busy covers CALC and FINISH, so it drops in the same cycle done rises.
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mdu_controller.sv
// ---------------------------------------------------------------------------
// tb_mdu_controller
//
// Directed bench for mdu_controller: every RV32M op with hand-computed
// results, divide-by-zero and signed overflow, back-to-back operation with
// start held high, and a reset that aborts a divide mid-flight.
// ---------------------------------------------------------------------------
module tb_mdu_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checkCount;
    int failCount;

    mdu_controller #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .func3     (func3),
        .rs1_value (rs1_value),
        .rs2_value (rs2_value),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    // 10 ns clock; inputs change on the falling edge, outputs are sampled
    // 1 ns after the rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Counts rising edges until done is seen (bounded), noting whether busy
    // ever dropped before done arrived.
    task automatic waitDone(output int edges, output logic busyDropped);
        edges = 0;
        busyDropped = 1'b0;
        while (edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) break;
            if (!busy) busyDropped = 1'b1;
        end
    endtask

    // Issues one operation, scrambles the inputs while it runs, and checks
    // acceptance, latency, busy hold, result and the single-cycle done pulse.
    task automatic applyStimulus(input string tag, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expected);
        int   edges;
        logic dropped;
        @(negedge clk);
        start     = 1'b1;
        func3     = f;
        rs1_value = a;
        rs2_value = b;
        @(posedge clk);
        #1;
        checkOutput({tag, "_busy_accept"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        start     = 1'b0;
        func3     = ~f;
        rs1_value = ~a;
        rs2_value = b ^ 32'h5A5A_A5A5;
        waitDone(edges, dropped);
        checkOutput({tag, "_latency"}, edges, 32'd33);
        checkOutput({tag, "_busy_hold"}, {31'd0, dropped}, 32'd0);
        checkOutput({tag, "_result"}, result, expected);
        checkOutput({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_result_held"}, result, expected);
    endtask

    initial begin
        int   edges;
        logic dropped;

        checkCount = 0;
        failCount  = 0;
        reset      = 1'b1;
        start      = 1'b0;
        func3      = 3'b000;
        rs1_value  = '0;
        rs2_value  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Multiply family
        applyStimulus("mul_7_m3",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        applyStimulus("mulh_m1_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        applyStimulus("mulhu_m1_m1",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        applyStimulus("mulhsu_m1_m1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus("mulh_m20_6",    3'b001, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFF);

        // Divide family
        applyStimulus("div_m20_6",     3'b100, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFD);
        applyStimulus("rem_m20_6",     3'b110, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFE);
        applyStimulus("divu_m20_6",    3'b101, 32'hFFFF_FFEC, 32'h0000_0006, 32'h2AAA_AAA7);
        applyStimulus("remu_m20_6",    3'b111, 32'hFFFF_FFEC, 32'h0000_0006, 32'h0000_0002);
        applyStimulus("div_100_7",     3'b100, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E);
        applyStimulus("rem_100_7",     3'b110, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002);

        // Divide by zero and signed overflow
        applyStimulus("div_by0",       3'b100, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF);
        applyStimulus("divu_by0",      3'b101, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF);
        applyStimulus("rem_by0",       3'b110, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678);
        applyStimulus("remu_by0",      3'b111, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678);
        applyStimulus("rem_neg_by0",   3'b110, 32'h8765_4321, 32'h0000_0000, 32'h8765_4321);
        applyStimulus("div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        applyStimulus("rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        // start held high: the second op is taken only after the first
        // completes, using the operands present at that point.
        @(negedge clk);
        start     = 1'b1;
        func3     = 3'b000;
        rs1_value = 32'h0000_0007;
        rs2_value = 32'hFFFF_FFFD;
        @(posedge clk);
        #1;
        @(negedge clk);
        func3     = 3'b011;
        rs1_value = 32'hFFFF_FFFF;
        rs2_value = 32'hFFFF_FFFF;
        waitDone(edges, dropped);
        checkOutput("hold_first_latency", edges, 32'd33);
        checkOutput("hold_first_busy", {31'd0, dropped}, 32'd0);
        checkOutput("hold_first_result", result, 32'hFFFF_FFEB);
        waitDone(edges, dropped);
        checkOutput("hold_done_gap", edges, 32'd34);
        checkOutput("hold_second_result", result, 32'hFFFF_FFFE);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("hold_idle_after", {31'd0, busy}, 32'd0);

        // Reset ten edges into a DIV aborts it with no done pulse
        @(negedge clk);
        start     = 1'b1;
        func3     = 3'b100;
        rs1_value = 32'hFFFF_FFEC;
        rs2_value = 32'h0000_0006;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // A stray done from the aborted op would break this latency check
        applyStimulus("after_abort_div", 3'b100, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFD);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/mdu_controller.md
Name: mdu_controller

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide operations that the single-cycle ALU does not implement.
- Sits beside the ALU in the execute stage. Decode raises start for OP (0110011) instructions with func7 = 0000001.
- The block holds the pipeline through busy and returns the result with a one-cycle done pulse.
- Contains the iteration FSM, 6-bit counter, shift-add multiplier, restoring divider and sign-correction logic.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- func3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_value  in  XLEN  operand A / dividend
- rs2_value  in  XLEN  operand B / divisor
- busy  out  1  operation in progress; pipeline must stall
- done  out  1  single-cycle pulse; result valid
- result  out  XLEN  result; held stable until the next accepted start

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, result=0, counter=0. Reset overrides start and aborts any operation in progress with no done pulse.

FSM states: IDLE, CALC, FINISH.

- IDLE
  - start=1 at edge E: latch func3, operand signs, |rs1| and |rs2| (magnitudes only for signed operands: MULH both; MULHSU rs1 only; DIV/REM both), counter=0.
  - Go to CALC; busy=1 from E.
  - start=0: stay in IDLE.
- CALC
  - One iteration per cycle; counter increments.
  - After the XLEN-th iteration (edge E+XLEN), go to FINISH.
  - start is ignored.
- FINISH
  - At edge E+XLEN+1: apply sign correction, write result, done=1, busy=0, return to IDLE.
  - done is high for exactly one cycle.
  - The earliest next start is accepted at edge E+XLEN+2. A start asserted during the done cycle is sampled in IDLE on the following edge.
- Latency: fixed at XLEN+1 = 33 edges from start acceptance to done for every op, including the special cases below. There is no early exit.

Multiply:
- Unsigned shift-add into a 2*XLEN product.
- Negate the product if the operand signs differ (signed variants only).
- MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].

Divide:
- Restoring, one quotient bit per cycle, on magnitudes.
- Quotient negated if signs differ (DIV only).
- Remainder takes the dividend's sign (REM only).

Special cases (resolved in FINISH):
- Divisor = 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1 as latched (raw value).
- Signed overflow, rs1=0x80000000 and rs2=0xFFFFFFFF: DIV → 0x80000000, REM → 0.

Inputs are sampled only at acceptance. Changes to rs1_value, rs2_value or func3 during CALC have no effect.

Test Plan:
- MUL 7 × -3 (rs1=0x00000007, rs2=0xFFFFFFFD), start at edge 0 → busy high at edges 1–33; done pulse after edge 33 only; result=0xFFFFFFEB.
- MULH/MULHU/MULHSU with rs1=rs2=0xFFFFFFFF → MULH 0x00000000, MULHU 0xFFFFFFFE, MULHSU 0xFFFFFFFF.
- DIV/REM rs1=-20 (0xFFFFFFEC), rs2=6 → DIV 0xFFFFFFFD (-3), REM 0xFFFFFFFE (-2); DIVU same operands → 0x2AAAAAA7.
- Divide by zero, rs1=0x12345678, rs2=0 → DIV/DIVU 0xFFFFFFFF, REM/REMU 0x12345678. Overflow case 0x80000000 / 0xFFFFFFFF → DIV 0x80000000, REM 0x00000000. All with 33-cycle latency.
- Hold start high continuously with changing operands → each op accepted only from IDLE; operand changes during CALC do not alter the result; consecutive done pulses are 34 edges apart.
- Assert reset at edge 10 of a DIV → next cycle busy=0, done=0, result=0; no done pulse; a new start immediately afterward completes correctly.
